// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with programmable hold time and optional saturating match counter.
// Define SEQ_DETECTOR_MOORE_CNT_EN to build the match_cnt register; otherwise match_cnt is tied to zero.
module seq_detector_moore #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 HOLD    = 2,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x_valid,
    input  logic             x,
    output logic             y,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_HIT    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PAT_LEN-1:0]  hist_q,  hist_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;

    logic [PAT_LEN-1:0]  nh;
    logic [FILL_W-1:0]   fill_inc;
    logic                consume;
    logic                detect;

    // The fill guard keeps the all-zero history after reset from matching a pattern with leading zeros.
    always_comb begin
        nh       = {hist_q[PAT_LEN-2:0], x};
        fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        consume  = en && x_valid && ((state_q == ST_SEARCH) || (state_q == ST_HIT));
        detect   = consume && (fill_q >= FILL_ARM) && (nh == PATTERN);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hold_d  = hold_q;

        if (!en) begin
            state_d = ST_IDLE;
            hist_d  = '0;
            fill_d  = '0;
            hold_d  = '0;
        end else begin
            if (consume) begin
                if (detect && !OVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end else begin
                    hist_d = nh;
                    fill_d = fill_inc;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (detect) begin
                        state_d = ST_HIT;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_HIT: begin
                    if (detect) begin
                        hold_d = HOLD_LOAD;
                    end else if (hold_q == '0) begin
                        state_d = ST_SEARCH;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

    assign y       = (state_q == ST_HIT);
    assign state_o = state_q;

`ifdef SEQ_DETECTOR_MOORE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Retriggers count as detections; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (detect && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_moore.sv
// Directed testbench for seq_detector_moore: four instances with different OVERLAP/HOLD/CNT_W share one stimulus.
module tb_seq_detector_moore;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, x_valid, x;

    logic       y_a, y_n, y_h, y_s;
    logic [1:0] st_a, st_n, st_h, st_s;
    logic [7:0] cnt_a, cnt_n, cnt_h;
    logic [1:0] cnt_s;

    int n_vec  = 0;
    int n_miss = 0;

    // Default: OVERLAP=1, HOLD=2, CNT_W=8
    seq_detector_moore u_a (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .y(y_a), .state_o(st_a), .match_cnt(cnt_a)
    );

    seq_detector_moore #(.OVERLAP(1'b0)) u_n (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .y(y_n), .state_o(st_n), .match_cnt(cnt_n)
    );

    seq_detector_moore #(.HOLD(4)) u_h (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .y(y_h), .state_o(st_h), .match_cnt(cnt_h)
    );

    seq_detector_moore #(.CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .en(en), .x_valid(x_valid), .x(x),
        .y(y_s), .state_o(st_s), .match_cnt(cnt_s)
    );

    function automatic int exp_cnt(input int n);
`ifdef SEQ_DETECTOR_MOORE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled at that point too.
    task automatic step(input logic v, input logic b);
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        rst = 1'b1;
        en  = 1'b1;
        step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 1'($urandom_range(0, 1)));
        rst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [3:0] s;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        n_vec++;
        if ({y_a, st_a, y_n, st_n, y_h, st_h, y_s, st_s} !== 12'h000) begin
            n_miss++;
            $display("FAIL reset_state: got %h want 000", {y_a, st_a, y_n, st_n, y_h, st_h, y_s, st_s});
        end
        n_vec++;
        if ({cnt_a, cnt_n, cnt_h, cnt_s} !== 26'h0) begin
            n_miss++;
            $display("FAIL reset_cnt: got %h want 0", {cnt_a, cnt_n, cnt_h, cnt_s});
        end
        rst = 1'b0;
        step(1'b1, 1'b1);
        n_vec++;
        if ({y_a, st_a} !== 3'b001) begin
            n_miss++;
            $display("FAIL reset_release: y/state=%b want 001", {y_a, st_a});
        end
        // The 1 on the IDLE->SEARCH edge must not be consumed, so 0,1,1 cannot complete 1011.
        s = 4'b0011;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, s[i]);
            n_vec++;
            if ({y_a, st_a} !== 3'b001) begin
                n_miss++;
                $display("FAIL idle_bit_consumed: y/state=%b want 001", {y_a, st_a});
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] s;
        s = 4'b1011;
        start();
        for (int i = 3; i >= 1; i--) begin
            step(1'b1, s[i]);
            n_vec++;
            if ({y_a, st_a} !== 3'b001) begin
                n_miss++;
                $display("FAIL basic_prefix: y/state=%b want 001", {y_a, st_a});
            end
        end
        step(1'b1, s[0]);
        n_vec++;
        if ({y_a, st_a} !== 3'b110) begin
            n_miss++;
            $display("FAIL basic_hit1: y/state=%b want 110", {y_a, st_a});
        end
        n_vec++;
        if (cnt_a !== 8'(exp_cnt(1))) begin
            n_miss++;
            $display("FAIL basic_cnt: got %0d want %0d", cnt_a, exp_cnt(1));
        end
        step(1'b0, 1'b0);
        n_vec++;
        if ({y_a, st_a} !== 3'b110) begin
            n_miss++;
            $display("FAIL basic_hit2: y/state=%b want 110", {y_a, st_a});
        end
        step(1'b0, 1'b1);
        n_vec++;
        if ({y_a, st_a} !== 3'b001) begin
            n_miss++;
            $display("FAIL basic_release: y/state=%b want 001", {y_a, st_a});
        end

        s = 4'b0011;
        start();
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, s[i]);
            n_vec++;
            if ({y_a, st_a} !== 3'b001) begin
                n_miss++;
                $display("FAIL nomatch: y/state=%b want 001", {y_a, st_a});
            end
        end
        n_vec++;
        if (cnt_a !== 8'd0) begin
            n_miss++;
            $display("FAIL nomatch_cnt: got %0d want 0", cnt_a);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1011011;
        start();
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s[i]);
            if (i == 3) begin
                n_vec++;
                if ({y_a, y_n} !== 2'b11) begin
                    n_miss++;
                    $display("FAIL overlap_first: y_ovl/y_novl=%b want 11", {y_a, y_n});
                end
            end
        end
        n_vec++;
        if ({y_a, y_n} !== 2'b10) begin
            n_miss++;
            $display("FAIL overlap_second: y_ovl/y_novl=%b want 10", {y_a, y_n});
        end
        n_vec++;
        if (cnt_a !== 8'(exp_cnt(2)) || cnt_n !== 8'(exp_cnt(1))) begin
            n_miss++;
            $display("FAIL overlap_cnt: got %0d/%0d want %0d/%0d", cnt_a, cnt_n, exp_cnt(2), exp_cnt(1));
        end
    endtask

    task automatic test_valid_gaps();
        logic [1:0] tv [9];
        tv = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11};
        start();
        for (int i = 0; i < 8; i++) begin
            step(tv[i][1], tv[i][0]);
            n_vec++;
            if ({y_a, st_a} !== 3'b001) begin
                n_miss++;
                $display("FAIL gap_prefix%0d: y/state=%b want 001", i, {y_a, st_a});
            end
        end
        step(tv[8][1], tv[8][0]);
        n_vec++;
        if ({y_a, st_a} !== 3'b110) begin
            n_miss++;
            $display("FAIL gap_hit1: y/state=%b want 110", {y_a, st_a});
        end
        step(1'b0, 1'b1);
        n_vec++;
        if ({y_a, st_a} !== 3'b110) begin
            n_miss++;
            $display("FAIL gap_hit2: y/state=%b want 110", {y_a, st_a});
        end
        step(1'b0, 1'b0);
        n_vec++;
        if ({y_a, st_a} !== 3'b001 || cnt_a !== 8'(exp_cnt(1))) begin
            n_miss++;
            $display("FAIL gap_end: y/state=%b cnt=%0d want 001 cnt=%0d", {y_a, st_a}, cnt_a, exp_cnt(1));
        end
    endtask

    task automatic test_retrigger();
        logic [6:0] s;
        s = 7'b1011011;
        start();
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s[i]);
            n_vec++;
            if (y_h !== (i <= 3)) begin
                n_miss++;
                $display("FAIL retrig_bit%0d: y=%b want %b", 7 - i, y_h, (i <= 3));
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            n_vec++;
            if ({y_h, st_h} !== 3'b110) begin
                n_miss++;
                $display("FAIL retrig_hold%0d: y/state=%b want 110", k, {y_h, st_h});
            end
        end
        step(1'b0, 1'b0);
        n_vec++;
        if ({y_h, st_h} !== 3'b001 || cnt_h !== 8'(exp_cnt(2))) begin
            n_miss++;
            $display("FAIL retrig_end: y/state=%b cnt=%0d want 001 cnt=%0d", {y_h, st_h}, cnt_h, exp_cnt(2));
        end
    endtask

    task automatic test_abort();
        logic [3:0] s;
        s = 4'b1011;
        start();
        for (int i = 3; i >= 0; i--) step(1'b1, s[i]);
        en = 1'b0;
        step(1'b1, 1'b0);
        n_vec++;
        if ({y_h, st_h} !== 3'b000 || cnt_h !== 8'(exp_cnt(1))) begin
            n_miss++;
            $display("FAIL abort_en: y/state=%b cnt=%0d want 000 cnt=%0d", {y_h, st_h}, cnt_h, exp_cnt(1));
        end
        en = 1'b1;
        step(1'b0, 1'b0);
        // History was cleared by en=0, so 0,1,1 must not complete 1011.
        s = 4'b0011;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, s[i]);
            n_vec++;
            if ({y_h, st_h} !== 3'b001) begin
                n_miss++;
                $display("FAIL abort_hist_clear: y/state=%b want 001", {y_h, st_h});
            end
        end
        s = 4'b1011;
        for (int i = 3; i >= 1; i--) step(1'b1, s[i]);
        en = 1'b0;
        step(1'b1, s[0]);
        n_vec++;
        if ({y_h, st_h} !== 3'b000 || cnt_h !== 8'(exp_cnt(1))) begin
            n_miss++;
            $display("FAIL en_priority: y/state=%b cnt=%0d want 000 cnt=%0d", {y_h, st_h}, cnt_h, exp_cnt(1));
        end
        en = 1'b1;

        start();
        for (int i = 3; i >= 0; i--) step(1'b1, s[i]);
        n_vec++;
        if ({y_h, st_h} !== 3'b110) begin
            n_miss++;
            $display("FAIL rst_pre_hit: y/state=%b want 110", {y_h, st_h});
        end
        rst = 1'b1;
        step(1'b1, 1'b1);
        n_vec++;
        if ({y_h, st_h} !== 3'b000 || cnt_h !== 8'd0) begin
            n_miss++;
            $display("FAIL rst_mid_hit: y/state=%b cnt=%0d want 000 cnt=0", {y_h, st_h}, cnt_h);
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] s;
        int e;
        s = 4'b1011;
        start();
        for (int k = 1; k <= 5; k++) begin
            for (int i = 3; i >= 0; i--) step(1'b1, s[i]);
            e = exp_cnt(k);
            if (e > 3) e = 3;
            n_vec++;
            if (cnt_s !== 2'(e)) begin
                n_miss++;
                $display("FAIL sat_cnt%0d: got %0d want %0d", k, cnt_s, e);
            end
            n_vec++;
            if (cnt_a !== 8'(exp_cnt(k)) || cnt_n !== 8'(exp_cnt(k))) begin
                n_miss++;
                $display("FAIL wide_cnt%0d: got %0d/%0d want %0d", k, cnt_a, cnt_n, exp_cnt(k));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gaps();
        test_retrigger();
        test_abort();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_detector_moore.md
Name: seq_detector_moore

Overview:
Parametrised Moore-type serial pattern detector. It watches a qualified 1-bit stream for a compile-time PATTERN of PAT_LEN bits. Overlapping or non-overlapping matching is selectable. On a match, a Moore output is asserted for a programmable hold time, and an optional saturating counter tallies detections. It sits on serial control/sync lines as the general successor to the fixed 4-state detectors.

Parameters:
PAT_LEN, 4, pattern length in bits; legal values are 2 to 32.
PATTERN, 4'b1011, target sequence; the MSB is the oldest bit and is received first.
OVERLAP, 1, 1 = history kept after a match (overlapping); 0 = history cleared after a match.
HOLD, 2, number of cycles y stays high per detection; must be at least 1.
CNT_W, 8, width of match_cnt.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  detector enable; when low, the block is forced to IDLE.
x_valid  input  1  qualifies x; a bit is consumed only when x_valid=1.
x  input  1  serial data bit.
y  output  1  match indication; Moore output, decoded from the state only.
state_o  output  2  current state encoding: IDLE=0, SEARCH=1, HIT=2.
match_cnt  output  CNT_W  saturating count of detections.

Behaviour:
- Reset: rst=1 at a rising edge sets state=IDLE, hist=0, fill=0, hold_cnt=0, y=0, match_cnt=0. Reset overrides every other input, including mid-HIT.
- History:
  - hist[PAT_LEN-1:0] is a shift register; the newest bit enters at the LSB.
  - fill counts consumed bits and saturates at PAT_LEN.
  - On a consumed bit: nh = {hist[PAT_LEN-2:0], x}; hist <= nh; fill <= min(fill+1, PAT_LEN).
- Detect event: en=1, x_valid=1, state is SEARCH or HIT, fill >= PAT_LEN-1, and nh == PATTERN.
  - The fill condition prevents false matches from reset zeros.
- States:
  - IDLE, y=0: history is not updated. Goes to SEARCH at the next edge when en=1. The bit present on that edge is not consumed.
  - SEARCH, y=0: bits are consumed. A detect event moves to HIT and loads hold_cnt=HOLD-1.
  - HIT, y=1: bits are still consumed.
    - A detect event in HIT reloads hold_cnt=HOLD-1 and stays in HIT (retrigger).
    - Otherwise, if hold_cnt==0, go to SEARCH; else decrement hold_cnt.
  - en=0 in any state: next state is IDLE, and hist and fill are cleared. match_cnt is preserved. en=0 takes priority over a simultaneous detect event, which is then ignored.
- Latency: the detect event occurs on the edge that samples the final bit; y is high from the following cycle for exactly HOLD cycles (absent retrigger).
- OVERLAP=0: on a detect event, hist <= 0 and fill <= 0 instead of the shifted value. The completing bit is not reused.
- OVERLAP=1: hist keeps nh, so the pattern's suffix can begin the next match.
- x_valid=0: hist, fill and detection are frozen; the state and hold countdown still advance.
- match_cnt: +1 on each detect event (including retriggers); saturates at 2^CNT_W-1 with no wrap.
- The state encoding value 3 is illegal and returns to IDLE on the next edge with y=0.

Optional Feature:
- Macro: SEQ_DETECTOR_MOORE_CNT_EN.
- Defined: the match_cnt register and increment logic are built as described above.
- Not defined: no counter flops are synthesised; match_cnt is tied to all zeros. All other behaviour is unchanged.

Test Plan:
- Reset: rst=1 with en=1 and random x -> y=0, state_o=0, match_cnt=0. Release rst -> state_o=1 one cycle later.
- Basic match (PATTERN=1011, HOLD=2): en=1, x_valid=1, x stream 1,0,1,1 -> y=1 during the 2 cycles after the 4th bit, then 0; match_cnt=1. Stream 0,0,1,1 -> no y pulse.
- Overlap: stream 1,0,1,1,0,1,1 with OVERLAP=1 -> 2 detect events (bits 4 and 7), match_cnt=2. Same stream with OVERLAP=0 -> 1 event, match_cnt=1.
- Valid gaps: bits 1,0,1,1 with x_valid=0 cycles (x toggling) between them -> exactly one detect, y timing relative to the last valid bit unchanged.
- Retrigger/abort (HOLD=4, OVERLAP=1): stream 1,0,1,1,0,1,1 -> y stays high continuously from the cycle after bit 4 until 4 cycles after bit 7. Repeat and drop en mid-HIT -> y=0 and state_o=0 the next cycle, match_cnt held. Assert rst mid-HIT -> all outputs 0.
- Saturation (CNT_W=2, macro defined): 5 separate matches -> match_cnt reads 1, 2, 3, 3, 3. Macro undefined -> match_cnt=0 throughout.
